// File: rtl/booth_mul_seq_pkg.sv
// Shared types for the radix-2 Booth sequential multiplier.
// State encoding and Booth recoding of the {Q[0], q_m1} bit pair.
package booth_mul_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        BC_HOLD0 = 2'b00,
        BC_ADD   = 2'b01,
        BC_SUB   = 2'b10,
        BC_HOLD1 = 2'b11
    } booth_code_e;

    function automatic booth_code_e booth_code(input logic q0, input logic q_m1);
        return booth_code_e'({q0, q_m1});
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
// The master side launches operations; the multiplier is the slave.
interface booth_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul_seq_addsub.sv
// Combinational (WIDTH+1)-bit adder/subtractor for the Booth accumulator.
// Subtraction inverts m and injects a carry-in of one.
module booth_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] m,
    input  logic           sub,
    output logic [WIDTH:0] sum
);
    logic [WIDTH:0] m_eff;
    logic [WIDTH:0] cin;

    always_comb begin
        m_eff = sub ? ~m : m;
        cin   = {{WIDTH{1'b0}}, sub};
        sum   = acc + m_eff + cin;
    end
endmodule

// File: rtl/booth_mul_seq.sv
// Radix-2 Booth sequential signed multiplier: WIDTH add/sub+shift cycles per product.
// state  | meaning
// IDLE   | waiting for start; product holds last result
// RUN    | one Booth iteration per cycle, busy high
// DONE   | single-cycle done pulse; start here launches the next operation
module booth_mul_seq
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mul_seq_if.slave   bus
);
    state_e                 state_q, state_d;
    logic [WIDTH:0]         m_q, m_d;
    logic [WIDTH:0]         acc_q, acc_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic                   qm1_q, qm1_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     product_q, product_d;

    booth_code_e            code;
    logic                   sub;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         acc_step;
    logic                   last_iter;

    booth_addsub #(.WIDTH(WIDTH)) u_addsub (
        .acc (acc_q),
        .m   (m_q),
        .sub (sub),
        .sum (sum)
    );

    always_comb begin
        code      = booth_code(q_q[0], qm1_q);
        sub       = (code == BC_SUB);
        acc_step  = ((code == BC_ADD) || (code == BC_SUB)) ? sum : acc_q;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    m_d     = {bus.a[WIDTH-1], bus.a};
                    q_d     = bus.b;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Arithmetic shift of {ACC,Q,q_m1}; Q[0] falls into q_m1.
                {acc_d, q_d, qm1_d} = {acc_step[WIDTH], acc_step, q_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    product_d = {acc_d[WIDTH-1:0], q_d};
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vectors plus a random sweep,
// with a cycle-level reference model compared on every falling edge.
module tb_booth_mul_seq;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    booth_mul_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_mul_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] smul(input logic [7:0] x, input logic [7:0] y);
        int xi;
        int yi;
        xi = int'($signed(x));
        yi = int'($signed(y));
        return 16'(xi * yi);
    endfunction

    // Reference model: an accepted start yields done WIDTH+1 edges later with the exact signed product.
    int          run_left;
    logic        exp_done;
    logic [15:0] exp_prod;
    logic [15:0] pend_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_left  <= 0;
            exp_done  <= 1'b0;
            exp_prod  <= '0;
            pend_prod <= '0;
        end else if (run_left > 0) begin
            run_left <= run_left - 1;
            exp_done <= (run_left == 1);
            if (run_left == 1) exp_prod <= pend_prod;
        end else begin
            exp_done <= 1'b0;
            if (bus.start) begin
                run_left  <= WIDTH;
                pend_prod <= smul(bus.a, bus.b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_busy", 32'(bus.busy), 32'(run_left > 0));
            chk("cyc_done", 32'(bus.done), 32'(exp_done));
            chk("cyc_product", 32'(bus.product), 32'(exp_prod));
        end
    end

    task automatic wait_done(input string nm, input int exp_lat, input logic [15:0] lit);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_product"}, 32'(bus.product), 32'(lit));
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] lit, input string nm);
        launch(a, b);
        wait_done(nm, WIDTH, lit);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_product", 32'(bus.product), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd3, 8'd5, 16'h000F, "mul_3x5");
        run_op(8'hFF, 8'h02, 16'hFFFE, "mul_m1x2");
        run_op(8'h01, 8'hFC, 16'hFFFC, "mul_1xm4");
        run_op(8'h80, 8'h80, 16'h4000, "mul_min_min");
        run_op(8'h7F, 8'h80, 16'hC080, "mul_max_min");
        run_op(8'h00, 8'h80, 16'h0000, "mul_0_min");

        // Start in the middle of a run is ignored.
        launch(8'd2, 8'd3);
        repeat (2) @(negedge clk);
        bus.a = 8'd9;
        bus.b = 8'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignored_start", WIDTH - 3, 16'h0006);

        // Back-to-back: start raised during the DONE cycle.
        run_op(8'd3, 8'd5, 16'h000F, "b2b_first");
        bus.a = 8'hF9;
        bus.b = 8'h06;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_second", WIDTH, 16'hFFD6);

        // Asynchronous reset in the middle of a run.
        launch(8'd3, 8'd5);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_product", 32'(bus.product), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd4, 8'd4, 16'h0010, "after_rst_4x4");

        for (int i = 0; i < 50; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, smul(ra, rb), "random");
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
